// File: rtl/dmem_sram_bridge.sv
// Data-memory slave: single-port SRAM behind a 2-entry posted-write buffer.
// Loads win the SRAM port. Buffered stores drain whenever no in-window load is accepted.
module dmem_sram_bridge #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int unsigned AW   = 14
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          dmem_wready,
    output logic          dmem_wvalid,
    input  logic [31:0]   dmem_waddr,
    input  logic [31:0]   dmem_wdata,
    input  logic [3:0]    dmem_wstrb,
    input  logic          dmem_rready,
    output logic          dmem_rvalid,
    input  logic [31:0]   dmem_raddr,
    output logic          dmem_rresp,
    output logic [31:0]   dmem_rdata,
    output logic          werr,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic [3:0]    sram_be,
    input  logic [31:0]   sram_rdata
);

    localparam logic [32:0] WinBytes = 33'd4 << AW;

    // Entry 0 is always the FIFO head
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_idx  [2];
    logic [31:0]   r_data [2];
    logic [3:0]    r_strb [2];
    logic          r_rd;
    logic          r_rerr;
    logic          r_werr;

    logic [31:0]   w_woff, w_roff;
    logic          w_wwin, w_rwin;
    logic [AW-1:0] w_widx, w_ridx;
    logic          w_hazard, w_rd, w_drain, w_push;
    logic [1:0]    w_cnt_m, w_cnt_d;
    logic          w_slot;
    logic [AW-1:0] w_idx_d  [2];
    logic [31:0]   w_data_d [2];
    logic [3:0]    w_strb_d [2];

    assign w_woff = dmem_waddr - BASE;
    assign w_roff = dmem_raddr - BASE;
    assign w_wwin = ({1'b0, w_woff} < WinBytes);
    assign w_rwin = ({1'b0, w_roff} < WinBytes);
    assign w_widx = w_woff[AW+1:2];
    assign w_ridx = w_roff[AW+1:2];

    // Buffer entries are always in-window, so an out-of-window read cannot alias one
    assign w_hazard = w_rwin && (((r_cnt != 2'd0) && (r_idx[0] == w_ridx)) ||
                                 ((r_cnt == 2'd2) && (r_idx[1] == w_ridx)));

    assign dmem_wvalid = dmem_wready && (r_cnt != 2'd2);
    assign dmem_rvalid = dmem_rready && !w_hazard && (r_cnt != 2'd2);

    // resetb gates the read port so the SRAM sees no access while reset is held
    assign w_rd    = dmem_rvalid && w_rwin && resetb;
    assign w_drain = (r_cnt != 2'd0) && !w_rd;
    assign w_push  = dmem_wvalid && w_wwin;

    assign sram_ce    = w_rd || w_drain;
    assign sram_we    = w_drain;
    assign sram_addr  = w_rd ? w_ridx : r_idx[0];
    assign sram_wdata = r_data[0];
    assign sram_be    = w_drain ? r_strb[0] : 4'h0;

    assign dmem_rresp = !r_rerr;
    assign dmem_rdata = r_rd ? sram_rdata : 32'h0;
    assign werr       = r_werr;

    assign w_cnt_m = r_cnt - {1'b0, w_drain};
    assign w_slot  = w_cnt_m[0];
    assign w_cnt_d = w_cnt_m + {1'b0, w_push};

    always_comb begin
        w_idx_d  = r_idx;
        w_data_d = r_data;
        w_strb_d = r_strb;
        if (w_drain) begin
            w_idx_d[0]  = r_idx[1];
            w_data_d[0] = r_data[1];
            w_strb_d[0] = r_strb[1];
        end
        if (w_push) begin
            w_idx_d[w_slot]  = w_widx;
            w_data_d[w_slot] = dmem_wdata;
            w_strb_d[w_slot] = dmem_wstrb;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt  <= 2'd0;
            r_rd   <= 1'b0;
            r_rerr <= 1'b0;
            r_werr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_idx[i]  <= '0;
                r_data[i] <= 32'h0;
                r_strb[i] <= 4'h0;
            end
        end else begin
            r_cnt  <= w_cnt_d;
            r_rd   <= w_rd;
            r_rerr <= dmem_rvalid && !w_rwin;
            r_werr <= dmem_wvalid && !w_wwin;
            r_idx  <= w_idx_d;
            r_data <= w_data_d;
            r_strb <= w_strb_d;
        end
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge with a behavioural SRAM model.
module tb_dmem_sram_bridge;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          resetb;
    logic          dmem_wready, dmem_wvalid;
    logic [31:0]   dmem_waddr, dmem_wdata;
    logic [3:0]    dmem_wstrb;
    logic          dmem_rready, dmem_rvalid;
    logic [31:0]   dmem_raddr;
    logic          dmem_rresp;
    logic [31:0]   dmem_rdata;
    logic          werr;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [3:0]    sram_be;
    logic [31:0]   sram_rdata;

    int n_checks = 0;
    int n_errs   = 0;
    int n_wr     = 0;
    int wr_snap;

    logic [31:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    dmem_sram_bridge #(.BASE(32'h0000_0000), .AW(AW)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .dmem_wready(dmem_wready),
        .dmem_wvalid(dmem_wvalid),
        .dmem_waddr (dmem_waddr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rready(dmem_rready),
        .dmem_rvalid(dmem_rvalid),
        .dmem_raddr (dmem_raddr),
        .dmem_rresp (dmem_rresp),
        .dmem_rdata (dmem_rdata),
        .werr       (werr),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_be    (sram_be),
        .sram_rdata (sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                n_wr <= n_wr + 1;
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply request inputs at the falling edge, then settle for combinational checks
    task automatic drive(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic rd, input logic [31:0] ra);
        @(negedge clk);
        dmem_wready = wr;
        dmem_waddr  = wa;
        dmem_wdata  = wd;
        dmem_wstrb  = ws;
        dmem_rready = rd;
        dmem_raddr  = ra;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        sram_rdata  = 32'h0;
        resetb      = 1'b0;
        dmem_wready = 1'b0;
        dmem_waddr  = 32'h0;
        dmem_wdata  = 32'h0;
        dmem_wstrb  = 4'h0;
        dmem_rready = 1'b0;
        dmem_raddr  = 32'h0;
        #12;
        chk("rst_rresp", {31'h0, dmem_rresp}, 32'h1);
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_werr", {31'h0, werr}, 32'h0);
        chk("rst_ce", {31'h0, sram_ce}, 32'h0);
        chk("rst_we", {31'h0, sram_we}, 32'h0);
        @(negedge clk);
        resetb = 1'b1;

        // Write, drain, read back
        drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        chk("t1_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        chk("t1_no_drain_same_cycle", {31'h0, sram_ce}, 32'h0);
        idle();
        chk("t1_drain_we", {31'h0, sram_we}, 32'h1);
        chk("t1_drain_addr", {18'h0, sram_addr}, 32'h4);
        chk("t1_drain_data", sram_wdata, 32'hDEADBEEF);
        chk("t1_drain_be", {28'h0, sram_be}, 32'hF);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10);
        chk("t1_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("t1_rd_ce", {30'h0, sram_ce, sram_we}, 32'h2);
        chk("t1_rd_addr", {18'h0, sram_addr}, 32'h4);
        idle();
        chk("t1_rresp", {31'h0, dmem_rresp}, 32'h1);
        chk("t1_rdata", dmem_rdata, 32'hDEADBEEF);
        idle();
        chk("t1_idle_rdata", dmem_rdata, 32'h0);

        // Partial-strobe merge with read-after-write stall
        drive(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0);
        idle();
        drive(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
        chk("t2_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20);
        chk("t2_hazard_stall", {31'h0, dmem_rvalid}, 32'h0);
        chk("t2_hazard_drain", {31'h0, sram_we}, 32'h1);
        chk("t2_drain_be", {28'h0, sram_be}, 32'h5);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20);
        chk("t2_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        idle();
        chk("t2_rdata", dmem_rdata, 32'h11BB33DD);

        // Three writes under a continuous non-hazard read stream
        drive(1'b1, 32'h30, 32'h11111111, 4'hF, 1'b1, 32'h100);
        chk("t3_c1_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        chk("t3_c1_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("t3_c1_rd_addr", {18'h0, sram_addr}, 32'h40);
        drive(1'b1, 32'h34, 32'h22222222, 4'hF, 1'b1, 32'h100);
        chk("t3_c2_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        chk("t3_c2_we", {31'h0, sram_we}, 32'h0);
        drive(1'b1, 32'h38, 32'h33333333, 4'hF, 1'b1, 32'h100);
        chk("t3_c3_full_wvalid", {31'h0, dmem_wvalid}, 32'h0);
        chk("t3_c3_full_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        chk("t3_c3_drain_addr", {17'h0, sram_we, sram_addr}, 32'h400C);
        chk("t3_c2_rresp", {31'h0, dmem_rresp}, 32'h1);
        drive(1'b1, 32'h38, 32'h33333333, 4'hF, 1'b1, 32'h100);
        chk("t3_c4_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        chk("t3_c4_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("t3_c4_we", {31'h0, sram_we}, 32'h0);
        idle();
        chk("t3_c5_drain", {17'h0, sram_we, sram_addr}, 32'h400D);
        chk("t3_c5_data", sram_wdata, 32'h22222222);
        idle();
        chk("t3_c6_drain", {17'h0, sram_we, sram_addr}, 32'h400E);
        chk("t3_c6_data", sram_wdata, 32'h33333333);
        idle();
        chk("t3_c7_empty", {31'h0, sram_ce}, 32'h0);

        // Out-of-window read and write
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10000);
        chk("t4_oow_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("t4_oow_rd_ce", {31'h0, sram_ce}, 32'h0);
        drive(1'b1, 32'h10000, 32'h12345678, 4'hF, 1'b0, 32'h0);
        chk("t4_oow_rresp", {31'h0, dmem_rresp}, 32'h0);
        chk("t4_oow_rdata", dmem_rdata, 32'h0);
        chk("t4_oow_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        chk("t4_oow_wr_ce", {31'h0, sram_ce}, 32'h0);
        idle();
        chk("t4_werr", {31'h0, werr}, 32'h1);
        chk("t4_no_sram_wr", {31'h0, sram_ce}, 32'h0);
        chk("t4_rresp_back", {31'h0, dmem_rresp}, 32'h1);
        idle();
        chk("t4_werr_pulse", {31'h0, werr}, 32'h0);

        // Simultaneous read and write to different words
        drive(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 32'h10);
        chk("t5_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("t5_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        chk("t5_rd_port", {17'h0, sram_we, sram_addr}, 32'h0004);
        idle();
        chk("t5_rdata", dmem_rdata, 32'hDEADBEEF);
        chk("t5_drain", {17'h0, sram_we, sram_addr}, 32'h4010);
        chk("t5_drain_data", sram_wdata, 32'hCAFEF00D);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h38);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40);
        chk("t5_rb_38", dmem_rdata, 32'h33333333);
        idle();
        chk("t5_rb_40", dmem_rdata, 32'hCAFEF00D);

        // Reset with two entries pending
        drive(1'b1, 32'h50, 32'h55555555, 4'hF, 1'b1, 32'h10);
        drive(1'b1, 32'h54, 32'h66666666, 4'hF, 1'b1, 32'h10);
        chk("t6_second_push", {31'h0, dmem_wvalid}, 32'h1);
        @(negedge clk);
        dmem_wready = 1'b0;
        dmem_rready = 1'b0;
        resetb      = 1'b0;
        wr_snap     = n_wr;
        #1;
        chk("t6_rst_ce", {31'h0, sram_ce}, 32'h0);
        chk("t6_rst_we", {31'h0, sram_we}, 32'h0);
        chk("t6_rst_rresp", {31'h0, dmem_rresp}, 32'h1);
        chk("t6_rst_rdata", dmem_rdata, 32'h0);
        chk("t6_rst_werr", {31'h0, werr}, 32'h0);
        @(negedge clk);
        resetb = 1'b1;
        idle();
        chk("t6_no_drain", {31'h0, sram_ce}, 32'h0);
        drive(1'b1, 32'h60, 32'h0, 4'h0, 1'b1, 32'h50);
        chk("t6_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("t6_wvalid", {31'h0, dmem_wvalid}, 32'h1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h54);
        chk("t6_rdata_50", dmem_rdata, 32'h0);
        chk("t6_no_hazard", {31'h0, dmem_rvalid}, 32'h1);
        idle();
        chk("t6_rdata_54", dmem_rdata, 32'h0);
        idle();
        chk("t6_pending_lost", n_wr - wr_snap, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Data-memory slave that sits directly downstream of the core/CLINT top level and terminates its `dmem_w*`/`dmem_r*` request ports on a single-port synchronous SRAM. A two-entry posted-write buffer lets stores retire in the cycle they are issued, and loads take priority on the SRAM port. Loads that hit a pending buffered store wait until that store has drained. Requests outside the SRAM window return an error response (reads) or are dropped (writes).

## Interface
- `BASE`, 32'h0000_0000: byte address of SRAM word 0.
- `AW`, 14: SRAM word-address width; window = 4·2^AW bytes.

- `clk` in 1: clock, all state on rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `dmem_wready` in 1: core write request.
- `dmem_wvalid` out 1: write accepted this cycle.
- `dmem_waddr` in 32, `dmem_wdata` in 32, `dmem_wstrb` in 4: write address, data and byte strobes.
- `dmem_rready` in 1: core read request.
- `dmem_rvalid` out 1: read accepted this cycle.
- `dmem_raddr` in 32: read address.
- `dmem_rresp` out 1: 1 = OKAY, 0 = out of window. Valid in the cycle after acceptance.
- `dmem_rdata` out 32: read data. Valid in the cycle after acceptance.
- `werr` out 1: one-cycle pulse when an accepted write is outside the window.
- `sram_ce`, `sram_we` out 1: SRAM access enable and write enable.
- `sram_addr` out AW: SRAM word address.
- `sram_wdata` out 32, `sram_be` out 4: SRAM write data and byte enables.
- `sram_rdata` in 32: SRAM read data, 1-cycle latency after a read `sram_ce`.

## Operation
- In-window test: `addr - BASE < 4·2^AW` (unsigned, 32-bit). Word index = `(addr - BASE) >> 2`; `addr[1:0]` ignored.
- Write buffer: 2-entry FIFO of {word index, data, strobes}, with `count` in 0..2.
  - `dmem_wvalid = dmem_wready && count < 2` (combinational).
  - An accepted in-window write is pushed. An out-of-window write is accepted but not pushed; `werr` pulses in the next cycle.
- Read hazard: the request word index equals the index of any valid buffer entry.
- `dmem_rvalid = dmem_rready && !hazard && count < 2` (combinational).
  - If the read is in-window: SRAM read this cycle (`sram_ce=1`, `sram_we=0`, `sram_addr`=index).
  - If out-of-window: no SRAM access.
- Drain: the FIFO head is written to the SRAM (`sram_ce=1`, `sram_we=1`, `sram_be`=strobes) in any cycle where `count > 0` and no in-window read is accepted. The head pops at the clock edge.
- Full buffer (`count==2`): reads are refused, so the buffer drains and frees a slot next cycle.
- Simultaneous push and pop: `count` unchanged. A push into an empty buffer is not drained in the same cycle.
- Response: `dmem_rresp`/`dmem_rdata` are driven in cycle T+1 for a read accepted in T.
  - In-window: `rresp=1`, `rdata=sram_rdata`.
  - Out-of-window: `rresp=0`, `rdata=0`.
  - With no read accepted in T: `rresp=1`, `rdata=0` in T+1.
- Reset (`resetb` low, any time): `count=0`, buffer contents discarded (pending writes lost), `dmem_rresp=1`, `dmem_rdata=0`, `werr=0`, `sram_ce=0`, `sram_we=0`. `dmem_wvalid`/`dmem_rvalid` follow their equations (buffer empty, so a request is accepted once `resetb` is high).

## Timing
- Write accept: 0-cycle (combinational on `dmem_wready`). Earliest SRAM write is the cycle after acceptance.
- Read: accept in T, data/resp in T+1. Back-to-back reads give one result per cycle.
- Read-after-write to the same word: refused until the matching entry has drained. Minimum 1 stall cycle if the write was accepted in the previous cycle.
- A continuous read stream starves drains until the buffer fills. The full-buffer rule then forces at least one drain per two cycles.
- All SRAM control outputs are combinational from registered state plus current requests. The SRAM samples them at the rising edge.

## Test plan
- Write `0x10`=`0xDEADBEEF`, strobe `4'hF`; idle; read `0x10` → `wvalid` in write cycle, SRAM write next cycle, `rdata=0xDEADBEEF`, `rresp=1` one cycle after read accept.
- Full-word write `0x20`=`0x11223344` and drain; then write `0x20`=`0xAABBCCDD` strobe `4'b0101` and read `0x20` the next cycle → `rvalid` low ≥1 cycle, then `rdata=0x11BB33DD`.
- Three back-to-back writes with `rready` held on a non-hazard address → `wvalid` low on the third until a drain frees a slot; `count` never exceeds 2.
- Read `BASE + 0x10000` with `AW=14` → `rvalid=1`, next cycle `rresp=0`, `rdata=0`, `sram_ce` low. Write to the same address → `wvalid=1`, `werr` pulse next cycle, no SRAM write.
- Read plus write in the same cycle to different words with an empty buffer → read goes to the SRAM, write is buffered, drain occurs next idle cycle.
- Assert `resetb` low with 2 entries pending → no SRAM write afterwards, `count=0`, outputs at reset values, and a subsequent read returns the old SRAM content.
